// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - two-slot round-robin CDB arbiter for five FU result producers
// Optional conflict counter enabled by defining CDB_ARB_PERF_CTR_EN.

package cdb_arbiter_pkg;
    localparam int CDB_PADDR_W = 7;

    typedef struct packed {
        logic                   cdb_broadcast;
        logic [4:0]             cdb_aaddr;
        logic [CDB_PADDR_W-1:0] cdb_p_addr;
        logic [31:0]            cdb_rd;
    } cdb_pkt_t;
endpackage

module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int N_REQ   = 5,
    parameter int PADDR_W = CDB_PADDR_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [N_REQ-1:0]                req_valid,
    output logic [N_REQ-1:0]                req_ready,
    input  logic [N_REQ-1:0][PADDR_W-1:0]   req_paddr,
    input  logic [N_REQ-1:0][4:0]           req_aaddr,
    input  logic [N_REQ-1:0][31:0]          req_rd,
    output cdb_pkt_t                        cdb_pkt,
    output cdb_pkt_t                        cdb_pkt2,
    output logic [31:0]                     conflict_cnt
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] g0;
    logic [PTR_W-1:0] g1;
    logic             g0_found;
    logic             g1_found;
    logic             grant_en;
    logic [PTR_W-1:0] last_grant;
    logic [PTR_W-1:0] ptr_next;
    cdb_pkt_t         slot0_pkt;
    cdb_pkt_t         slot1_pkt;

    // Cyclic scan from rr_ptr for g0, then from g0+1 for g1 (g0 itself is never revisited).
    always_comb begin
        int idx;
        g0       = '0;
        g1       = '0;
        g0_found = 1'b0;
        g1_found = 1'b0;
        idx      = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!g0_found && req_valid[idx]) begin
                g0_found = 1'b1;
                g0       = PTR_W'(idx);
            end
        end
        for (int k = 0; k < N_REQ - 1; k++) begin
            idx = int'(g0) + 1 + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (g0_found && !g1_found && req_valid[idx]) begin
                g1_found = 1'b1;
                g1       = PTR_W'(idx);
            end
        end
    end

    assign grant_en   = g0_found && !flush && !rst;
    assign last_grant = g1_found ? g1 : g0;
    assign ptr_next   = (int'(last_grant) == N_REQ - 1) ? '0 : last_grant + 1'b1;

    always_comb begin
        req_ready = '0;
        if (grant_en) begin
            req_ready[g0] = 1'b1;
            if (g1_found) req_ready[g1] = 1'b1;
        end
    end

    always_comb begin
        slot0_pkt = '0;
        slot1_pkt = '0;
        if (grant_en) begin
            slot0_pkt.cdb_broadcast = 1'b1;
            slot0_pkt.cdb_aaddr     = req_aaddr[g0];
            slot0_pkt.cdb_p_addr    = req_paddr[g0];
            slot0_pkt.cdb_rd        = req_rd[g0];
            if (g1_found) begin
                slot1_pkt.cdb_broadcast = 1'b1;
                slot1_pkt.cdb_aaddr     = req_aaddr[g1];
                slot1_pkt.cdb_p_addr    = req_paddr[g1];
                slot1_pkt.cdb_rd        = req_rd[g1];
            end
        end
    end

    // Idle slots register all-zero so broadcast lasts exactly one cycle per result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_pkt  <= '0;
            cdb_pkt2 <= '0;
            rr_ptr   <= '0;
        end else begin
            cdb_pkt  <= slot0_pkt;
            cdb_pkt2 <= slot1_pkt;
            if (grant_en) rr_ptr <= ptr_next;
        end
    end

`ifdef CDB_ARB_PERF_CTR_EN
    logic [31:0] conflict_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_q <= '0;
        end else if (!flush && ($countones(req_valid) > 2) && (conflict_q != 32'hFFFF_FFFF)) begin
            conflict_q <= conflict_q + 32'd1;
        end
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = 32'd0;
`endif

endmodule
